// File: rtl/hex_word_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hex_word_uart_tx
// Purpose  : Serialises the eight ASCII hex characters produced by the
//            value-to-ASCII converter onto a UART TX pin as back-to-back
//            8N1 frames, most significant character first.
//
//            A single `send` pulse snapshots all characters into a shadow
//            register, so the inputs may change freely while the line is
//            going out.
//
// Option   : `LINE_TERM_EN` appends CR (0x0D) and LF (0x0A) frames after
//            ascii_0, giving a 10-frame line. When it is undefined the
//            line is exactly 8 frames.
//
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous, active-high reset
//            ascii_7  - first character sent (most significant nibble)
//            ascii_6..ascii_1 - middle characters
//            ascii_0  - last data character
//            send     - start request, ignored while busy
//            busy     - high from acceptance of send until line complete
//            done     - one-cycle pulse as the final stop bit completes
//            tx_out   - UART serial output, idle high
//
// Revision : 1.0 - initial release
// ============================================================================
module hex_word_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_7,
    input  logic [7:0] ascii_6,
    input  logic [7:0] ascii_5,
    input  logic [7:0] ascii_4,
    input  logic [7:0] ascii_3,
    input  logic [7:0] ascii_2,
    input  logic [7:0] ascii_1,
    input  logic [7:0] ascii_0,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       tx_out
);

`ifdef LINE_TERM_EN
    localparam int c_num_chars = 10;
`else
    localparam int c_num_chars = 8;
`endif
    localparam int                  c_idx_w     = $clog2(c_num_chars);
    localparam int                  c_baud_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0]  c_char_last = c_idx_w'(c_num_chars - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_baud_w-1:0] r_baud_cnt;
    logic [c_baud_w-1:0] w_baud_nxt;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_nxt;
    logic [c_idx_w-1:0]  r_char_idx;
    logic [c_idx_w-1:0]  w_char_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                w_load;
    logic                w_baud_last;
    logic [7:0]          w_cur_byte;
    logic [7:0]          r_shadow [c_num_chars];

    assign w_baud_last = (r_baud_cnt == c_baud_last);
    assign w_cur_byte  = r_shadow[r_char_idx];

    // Snapshot of the line; only written on acceptance of send, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_shadow[0] <= ascii_7;
            r_shadow[1] <= ascii_6;
            r_shadow[2] <= ascii_5;
            r_shadow[3] <= ascii_4;
            r_shadow[4] <= ascii_3;
            r_shadow[5] <= ascii_2;
            r_shadow[6] <= ascii_1;
            r_shadow[7] <= ascii_0;
`ifdef LINE_TERM_EN
            r_shadow[8] <= 8'h0D;
            r_shadow[9] <= 8'h0A;
`endif
        end
    end

    // State and counter registers. tx_out is registered so the pin is
    // glitch-free; it therefore follows the state by one clock, which
    // puts the start bit on the edge after the one that accepts send.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_char_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_char_idx <= w_char_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_idx;
        w_char_nxt  = r_char_idx;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_tx_nxt    = 1'b1;
        // Every bit-time state simply counts and wraps the baud counter.
        w_baud_nxt  = w_baud_last ? '0 : r_baud_cnt + c_baud_w'(1);

        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (send) begin
                    w_load      = 1'b1;
                    w_state_nxt = START;
                    w_char_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_last) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                end
            end
            DATA: begin
                w_tx_nxt = w_cur_byte[r_bit_idx];
                if (w_baud_last) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_last) begin
                    // The index stops at the last character, it is never
                    // advanced past it.
                    if (r_char_idx == c_char_last) begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_char_nxt  = r_char_idx + c_idx_w'(1);
                        w_state_nxt = START;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign tx_out = r_tx;

endmodule
`default_nettype wire
